// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg: mode encodings and product-width helper shared by the approximate multiplier
package approx_mul_pkg;
  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction
endpackage

// File: rtl/approx_pp_col.sv
// approx_pp_col: combinational partial-product column counter with low-column masking
// Ports: a_i, b_i operands; mode_i selects exact/approx; col_o[k] = number of set
// partial-product bits of weight 2^k (columns below TRUNC are zero in approx mode).
module approx_pp_col
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4,
  localparam int PW = prod_width(WIDTH),
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]      a_i,
  input  logic [WIDTH-1:0]      b_i,
  input  logic                  mode_i,
  output logic [PW-1:0][CW-1:0] col_o
);
  always_comb begin
    col_o = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        if (!(mode_i == MODE_APPROX && i + j < TRUNC)) col_o[i+j] = col_o[i+j] + CW'(a_i[i] & b_i[j]);
  end
endmodule

// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: elastic pipelined unsigned multiplier with per-transaction truncated mode
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/a/b/mode input handshake;
// out_valid/out_ready/o/o_mode output handshake; txn_count counts output handshakes.
// Stage 0 holds column counts, stage 1 compresses them into the product, later stages
// only carry it; with a single stage the compression sits after the stage-0 register.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int TRUNC  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   o,
  output logic                 o_mode,
  output logic [15:0]          txn_count
);
  localparam int PW = prod_width(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PS = STAGES > 1 ? STAGES - 1 : 1;
  logic [PW-1:0][CW-1:0] col, col_q, col_d;
  logic [PW-1:0] sum, res;
  logic [PS-1:0][PW-1:0] prod_q, prod_d;
  logic [STAGES-1:0] valid_q, valid_d, mode_q, mode_d, en;
  logic [15:0] txn_q, txn_d;
  approx_pp_col #(.WIDTH(WIDTH), .TRUNC(TRUNC)) u_col (
    .a_i(a),
    .b_i(b),
    .mode_i(mode),
    .col_o(col)
  );
  // en[k]: stage k may load this cycle (it is empty or its content moves on)
  always_comb begin
    en[STAGES-1] = !valid_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) en[k] = !valid_q[k] || en[k+1];
  end
  always_comb begin
    sum = '0;
    for (int k = 0; k < PW; k++) sum = sum + (PW'(col_q[k]) << k);
  end
  always_comb begin
    col_d      = en[0] ? col : col_q;
    mode_d     = mode_q;
    valid_d    = valid_q;
    prod_d     = prod_q;
    mode_d[0]  = en[0] ? mode : mode_q[0];
    valid_d[0] = en[0] ? in_valid : valid_q[0];
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k]  = en[k] ? valid_q[k-1] : valid_q[k];
      mode_d[k]   = en[k] ? mode_q[k-1] : mode_q[k];
      prod_d[k-1] = !en[k] ? prod_q[k-1] : k == 1 ? sum : prod_q[k > 1 ? k - 2 : 0];
    end
    txn_d = txn_q + 16'(out_valid && out_ready);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= '0;
      txn_q   <= '0;
    end else begin
      valid_q <= valid_d;
      txn_q   <= txn_d;
    end
  always_ff @(posedge clk) begin
    col_q  <= col_d;
    mode_q <= mode_d;
    prod_q <= prod_d;
  end
  assign res       = STAGES == 1 ? sum : prod_q[PS-1];
  assign in_ready  = en[0];
  assign out_valid = valid_q[STAGES-1];
  // datapath registers are never reset, so outputs are forced to zero while empty
  assign o         = out_valid ? res : '0;
  assign o_mode    = out_valid & mode_q[STAGES-1];
  assign txn_count = txn_q;
endmodule

// File: tb/tb_approx_mul_pipe.sv
// tb_approx_mul_pipe: randomized scoreboard bench for approx_mul_pipe
module tb_approx_mul_pipe;
  localparam int W = 8, S = 2, T = 4, PW = 2 * W;
  logic clk = 0, rst_n = 0, in_valid = 0, mode = 0, out_ready = 0;
  logic in_ready, out_valid, o_mode;
  logic [W-1:0] a = '0, b = '0;
  logic [PW-1:0] o;
  logic [15:0] txn_count;
  int checks = 0, failures = 0;
  logic acc, del;
  logic [PW:0] exp_q[$];

  approx_mul_pipe #(.WIDTH(W), .STAGES(S), .TRUNC(T)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .o(o), .o_mode(o_mode),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  // exact product minus the weight of every dropped partial-product bit
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
    int unsigned p, dropped;
    p = x;
    p = p * y;
    dropped = 0;
    if (m)
      for (int i = 0; i < W; i++)
        for (int j = 0; j < W; j++)
          if (i + j < T && x[i] && y[j]) dropped += 1 << (i + j);
    return PW'(p - dropped);
  endfunction

  task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic m, input logic r);
    @(posedge clk);
    #1;
    in_valid = v; a = x; b = y; mode = m; out_ready = r;
    @(negedge clk);
    acc = in_valid && in_ready;
    del = out_valid && out_ready;
    if (acc) exp_q.push_back({m, ref_mul(x, y, m)});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 0; in_valid = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    checks++; if (o !== '0 || o_mode !== 1'b0) begin failures++; $display("FAIL reset_o got=%0d/%0b want=0/0", o, o_mode); end
    checks++; if (txn_count !== 16'd0) begin failures++; $display("FAIL reset_txn got=%0d want=0", txn_count); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0 || o !== '0) begin failures++; $display("FAIL post_reset_out got=%0b/%0d want=0/0", out_valid, o); end
  endtask

  task automatic test_exact();
    do_reset();
    step(1, 8'd255, 8'd255, 1'b0, 1);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL exact_accept got=%0b want=1", acc); end
    for (int k = 1; k < S; k++) begin
      step(0, 0, 0, 0, 1);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL exact_early got=%0b want=0", out_valid); end
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || o !== 16'd65025 || o_mode !== 1'b0) begin
      failures++; $display("FAIL exact_result got v=%0b o=%0d m=%0b want v=1 o=65025 m=0", out_valid, o, o_mode);
    end
    if (del && exp_q.size() != 0) void'(exp_q.pop_front());
    step(0, 0, 0, 0, 1);
    checks++; if (txn_count !== 16'd1) begin failures++; $display("FAIL exact_txn got=%0d want=1", txn_count); end
  endtask

  task automatic test_approx();
    logic [PW-1:0] lit [2];
    int n;
    lit[0] = 16'd64976;
    lit[1] = 16'd176;
    n = 0;
    do_reset();
    step(1, 8'd255, 8'd255, 1'b1, 1);
    step(1, 8'd15, 8'd15, 1'b1, 1);
    for (int c = 0; c < 10 && n < 2; c++) begin
      step(0, 0, 0, 0, 1);
      if (del) begin
        checks++;
        if (o !== lit[n] || o_mode !== 1'b1) begin
          failures++; $display("FAIL approx_result%0d got o=%0d m=%0b want o=%0d m=1", n, o, o_mode, lit[n]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        n++;
      end
    end
    checks++; if (n != 2) begin failures++; $display("FAIL approx_count got=%0d want=2", n); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] xa [5];
    logic [W-1:0] xb [5];
    logic [PW-1:0] held;
    logic held_m, have;
    int sent, got;
    sent = 0; got = 0; have = 0; held = '0; held_m = 0;
    for (int i = 0; i < 5; i++) begin xa[i] = W'($urandom); xb[i] = W'($urandom); end
    do_reset();
    for (int c = 0; c < 60 && got < 5; c++) begin
      step(sent < 5, xa[sent < 5 ? sent : 0], xb[sent < 5 ? sent : 0], sent[0], c >= 4);
      if (acc) sent++;
      if (c == 3) begin
        checks++;
        if (sent != S || in_ready !== 1'b0) begin
          failures++; $display("FAIL bp_fill got accepts=%0d in_ready=%0b want accepts=%0d in_ready=0", sent, in_ready, S);
        end
      end
      if (out_valid && !out_ready) begin
        if (have) begin
          checks++;
          if (o !== held || o_mode !== held_m) begin
            failures++; $display("FAIL bp_hold got o=%0d m=%0b want o=%0d m=%0b", o, o_mode, held, held_m);
          end
        end
        held = o; held_m = o_mode; have = 1;
      end
      if (del) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL bp_extra got o=%0d want no result", o);
        end else if (o !== exp_q[0][PW-1:0] || o_mode !== exp_q[0][PW]) begin
          failures++; $display("FAIL bp_data got o=%0d m=%0b want o=%0d m=%0b", o, o_mode, exp_q[0][PW-1:0], exp_q[0][PW]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
    end
    step(0, 0, 0, 0, 1);
    checks++; if (got != 5) begin failures++; $display("FAIL bp_count got=%0d want=5", got); end
    checks++; if (txn_count !== 16'd5 || out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_txn got txn=%0d v=%0b want txn=5 v=0", txn_count, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic stale;
    do_reset();
    step(1, W'($urandom), W'($urandom), 1'b0, 0);
    step(1, W'($urandom), W'($urandom), 1'b1, 0);
    step(0, 0, 0, 0, 0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_prefill got=%0b want=1", out_valid); end
    #1 rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || o !== '0 || txn_count !== 16'd0) begin
      failures++; $display("FAIL mid_clear got v=%0b o=%0d txn=%0d want 0/0/0", out_valid, o, txn_count);
    end
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%0b want=1", in_ready); end
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 0, 0, 1);
      if (out_valid !== 1'b0) stale = 1;
    end
    checks++; if (stale) begin failures++; $display("FAIL mid_stale got out_valid=1 want 0"); end
    step(1, 8'd77, 8'd201, 1'b0, 1);
    lat = 0;
    for (int c = 1; c < 10 && lat == 0; c++) begin
      step(0, 0, 0, 0, 1);
      if (out_valid) begin
        lat = c;
        checks++;
        if (exp_q.size() == 0 || o !== exp_q[0][PW-1:0]) begin
          failures++; $display("FAIL mid_result got o=%0d want o=%0d", o, ref_mul(8'd77, 8'd201, 1'b0));
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    checks++; if (lat != S) begin failures++; $display("FAIL mid_latency got=%0d want=%0d", lat, S); end
  endtask

  task automatic test_random();
    int nacc;
    nacc = 0;
    do_reset();
    for (int c = 0; c < 420; c++) begin
      if (c < 400) step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), nacc[0], $urandom_range(0, 3) != 0);
      else step(0, 0, 0, 0, 1);
      if (acc) nacc++;
      if (del) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_extra got o=%0d want no result", o);
        end else if (o !== exp_q[0][PW-1:0] || o_mode !== exp_q[0][PW]) begin
          failures++; $display("FAIL rand_result got o=%0d m=%0b want o=%0d m=%0b", o, o_mode, exp_q[0][PW-1:0], exp_q[0][PW]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    step(0, 0, 0, 0, 1);
    checks++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rand_drain got pending=%0d v=%0b want 0/0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_wrap();
    int sent;
    logic seen;
    sent = 0;
    do_reset();
    for (int c = 0; c < 70000 && (sent < 65535 || exp_q.size() != 0); c++) begin
      step(sent < 65535, W'(c), W'(c >> 3), c[0], 1);
      if (acc) sent++;
      if (del && exp_q.size() != 0) void'(exp_q.pop_front());
    end
    step(0, 0, 0, 0, 1);
    checks++; if (txn_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%0d want=65535", txn_count); end
    step(1, 8'd200, 8'd100, 1'b0, 1);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(0, 0, 0, 0, 1);
      if (del) begin
        seen = 1;
        checks++;
        if (o !== 16'd20000) begin failures++; $display("FAIL wrap_result got=%0d want=20000", o); end
      end
    end
    step(0, 0, 0, 0, 1);
    checks++; if (txn_count !== 16'd0) begin failures++; $display("FAIL wrap_txn got=%0d want=0", txn_count); end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/approx_mul_pipe.md
APPROX_MUL_PIPE -- requirements
Module: approx_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal 4..16).
REQ-002 SHALL have parameter STAGES, default 2, meaning pipeline register count (legal 1..4).
REQ-003 SHALL have parameter TRUNC, default 4, meaning low product columns dropped in approximate mode (legal 0..WIDTH).
REQ-004 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, operand pair and mode present.
REQ-007 SHALL have port in_ready, output, 1, block accepts the input this cycle.
REQ-008 SHALL have port a, input, WIDTH, unsigned multiplicand.
REQ-009 SHALL have port b, input, WIDTH, unsigned multiplier.
REQ-010 SHALL have port mode, input, 1, where 0 means exact and 1 means truncated approximation.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have port o, output, 2*WIDTH, product.
REQ-014 SHALL have port o_mode, output, 1, mode that travelled with the result.
REQ-015 SHALL have port txn_count, output, 16, count of completed output handshakes.

Function
REQ-016 SHALL compute, in exact mode, o = a*b for the full 2*WIDTH bits.
REQ-017 SHALL compute, in approx mode, o = sum of a[i]&b[j]<<(i+j) over all i+j >= TRUNC, with o[TRUNC-1:0] = 0; TRUNC=0 SHALL equal exact.
REQ-018 SHALL set mode per transaction; mixed modes in flight SHALL not interact.
REQ-019 SHALL accept an input when in_valid && in_ready, and deliver an output when out_valid && out_ready.
REQ-020 SHALL use an elastic pipeline: stage k advances when stage k+1 is empty or advancing; the last stage advances on out_ready.
REQ-021 SHALL drive in_ready = !stage0_valid || stage0_advances, combinationally; it SHALL not depend on in_valid.
REQ-022 SHALL produce the result, with no stall, STAGES cycles after acceptance, i.e. out_valid rises on edge STAGES after the accept edge.
REQ-023 SHALL sustain one result per cycle when out_ready is held at 1.
REQ-024 SHALL hold o, o_mode and out_valid stable while out_valid && !out_ready; no result SHALL be lost or duplicated.
REQ-025 SHALL allow a simultaneous accept and deliver on a full pipeline in the same cycle.
REQ-026 SHALL increment txn_count by 1 per output handshake, wrapping 65535 -> 0.
REQ-027 SHALL let partial-product generation and column compression be split across stages; only the final stage output SHALL be architecturally visible.

Reset
REQ-028 SHALL, on rst_n low, immediately clear all stage valid bits, out_valid and txn_count, independent of clk.
REQ-029 SHALL drive o = 0 and o_mode = 0 while in reset and after it.
REQ-030 SHALL discard in-flight transactions when reset asserts mid-operation; the first post-reset accept SHALL then see an empty pipeline.
REQ-031 SHALL drive in_ready = 1 on the first cycle after rst_n deasserts.

Structure
REQ-032 SHALL place the mode encoding constants (MODE_EXACT=0, MODE_APPROX=1) and a product-width helper function in package approx_mul_pkg.
REQ-033 SHALL use one sub-module, approx_pp_col, which is combinational and produces the masked partial-product column sums for a given TRUNC; all sequencing SHALL stay in the top module.
REQ-034 SHALL keep datapath storage registers without reset; only valid bits and txn_count SHALL be reset.

Verification
REQ-035 SHALL cover: WIDTH=8, mode=0, a=255, b=255, out_ready=1 -> o=65025 exactly 2 cycles after accept, txn_count=1.
REQ-036 SHALL cover: mode=1, TRUNC=4, a=255, b=255 -> o=64976; and a=15, b=15 -> o=176.
REQ-037 SHALL cover: 5 back-to-back accepts, out_ready=0 for 4 cycles -> in_ready drops after STAGES accepts, o held, then 5 results in order, txn_count=5.
REQ-038 SHALL cover: rst_n pulsed low mid-stream with 2 transactions in flight -> out_valid=0 same cycle, no stale result later, txn_count=0.
REQ-039 SHALL cover: alternating mode 0/1 stream with random operands against a reference model -> every o and o_mode match in order.
REQ-040 SHALL cover: txn_count preloaded by 65535 handshakes, then one more -> txn_count=0.
